// File: rtl/mult8x8_seq_ctrl_if.sv
// Control bundle between the 8x8 multiplier top level and its sequencer.
// Latency: wires only; all timing lives in the sequencer.
// Backpressure: none; start is a request sampled only while idle. Optional abort with MULT_CTRL_ABORT_EN.
interface mult8x8_seq_ctrl_if;
  logic       start;
`ifdef MULT_CTRL_ABORT_EN
  logic       abort;
`endif
  logic       sel_a;
  logic       sel_b;
  logic [1:0] shift_sel;
  logic       acc_clr;
  logic       acc_en;
  logic       busy;
  logic       done;
  logic [2:0] state_out;

`ifdef MULT_CTRL_ABORT_EN
  modport master (
    output start, abort,
    input  sel_a, sel_b, shift_sel, acc_clr, acc_en, busy, done, state_out
  );
  modport slave (
    input  start, abort,
    output sel_a, sel_b, shift_sel, acc_clr, acc_en, busy, done, state_out
  );
`else
  modport master (
    output start,
    input  sel_a, sel_b, shift_sel, acc_clr, acc_en, busy, done, state_out
  );
  modport slave (
    input  start,
    output sel_a, sel_b, shift_sel, acc_clr, acc_en, busy, done, state_out
  );
`endif
endinterface

// File: rtl/mult8x8_seq_ctrl.sv
// Moore sequencer stepping one shared 4x4 multiplier through the four partial products of an 8x8 multiply.
// Latency: start edge -> [CLR 1] -> CALC 4 -> DONE for DONE_CYCLES; all outputs registered.
// Backpressure: start is ignored (not queued) outside IDLE. MULT_CTRL_ABORT_EN adds abort from CLR/CALC.
module mult8x8_seq_ctrl #(
  parameter int unsigned DONE_CYCLES = 1,
  parameter bit          AUTO_CLEAR  = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  mult8x8_seq_ctrl_if.slave  bus
);

`ifdef MULT_CTRL_ABORT_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    CALC  = 3'd2,
    DONE  = 3'd3,
    ABORT = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    CALC  = 3'd2,
    DONE  = 3'd3
  } state_t;
`endif

  // Last value of the done-hold counter before returning to IDLE.
  localparam logic [3:0] DONE_LAST = 4'(DONE_CYCLES - 1);

  state_t     state, nxt_state;
  logic [1:0] step, nxt_step;
  logic [3:0] cnt, nxt_cnt;

  logic       nxt_calc;
  logic       nxt_sel_a, nxt_sel_b;
  logic [1:0] nxt_shift_sel;

  // Next-state logic plus decode of the next state into the values the output registers load.
  always_comb begin
    nxt_state = state;
    nxt_step  = step;
    nxt_cnt   = cnt;
    case (state)
      IDLE: begin
        if (bus.start) begin
          nxt_step  = 2'd0;
          nxt_state = AUTO_CLEAR ? CLR : CALC;
        end
      end
      CLR: begin
        nxt_step  = 2'd0;
        nxt_state = CALC;
`ifdef MULT_CTRL_ABORT_EN
        if (bus.abort) nxt_state = ABORT;
`endif
      end
      CALC: begin
        // 2-bit step wraps to 0 naturally on the exit to DONE.
        nxt_step = step + 2'd1;
        if (step == 2'd3) begin
          nxt_state = DONE;
          nxt_cnt   = 4'd0;
        end
`ifdef MULT_CTRL_ABORT_EN
        if (bus.abort) begin
          nxt_state = ABORT;
          nxt_step  = 2'd0;
        end
`endif
      end
      DONE: begin
        if (cnt == DONE_LAST) begin
          nxt_state = IDLE;
        end else begin
          nxt_cnt = cnt + 4'd1;
        end
      end
`ifdef MULT_CTRL_ABORT_EN
      ABORT: begin
        nxt_state = IDLE;
        nxt_step  = 2'd0;
      end
`endif
      default: begin
        nxt_state = IDLE;
        nxt_step  = 2'd0;
        nxt_cnt   = 4'd0;
      end
    endcase

    // Step 0..3 maps to (a_lo,b_lo,<<0) (a_hi,b_lo,<<4) (a_lo,b_hi,<<4) (a_hi,b_hi,<<8).
    nxt_calc      = (nxt_state == CALC);
    nxt_sel_a     = nxt_calc & nxt_step[0];
    nxt_sel_b     = nxt_calc & nxt_step[1];
    nxt_shift_sel = nxt_calc ? {nxt_step[1] & nxt_step[0], nxt_step[1] ^ nxt_step[0]} : 2'd0;
  end

  // State, step, done counter and registered Moore outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      step          <= 2'd0;
      cnt           <= 4'd0;
      bus.sel_a     <= 1'b0;
      bus.sel_b     <= 1'b0;
      bus.shift_sel <= 2'd0;
      bus.acc_clr   <= 1'b0;
      bus.acc_en    <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.state_out <= 3'd0;
    end else begin
      state         <= nxt_state;
      step          <= nxt_step;
      cnt           <= nxt_cnt;
      bus.sel_a     <= nxt_sel_a;
      bus.sel_b     <= nxt_sel_b;
      bus.shift_sel <= nxt_shift_sel;
      bus.acc_clr   <= (nxt_state == CLR);
      bus.acc_en    <= nxt_calc;
      bus.busy      <= (nxt_state != IDLE);
      bus.done      <= (nxt_state == DONE);
      bus.state_out <= nxt_state;
    end
  end

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// Directed bench for the 8x8 multiplier sequencer with a behavioural datapath model.
// Latency: checks every cycle of each operation against hand-derived vectors.
// Backpressure: exercises ignored start requests, mid-operation reset and (with the macro) abort.
module tb_mult8x8_seq_ctrl;

  // Observed vector layout: {sel_a, sel_b, shift_sel[1:0], acc_clr, acc_en, busy, done, state_out[2:0]}
  localparam logic [10:0] EXP_IDLE  = 11'b0_0_00_0_0_0_0_000;
  localparam logic [10:0] EXP_CLR   = 11'b0_0_00_1_0_1_0_001;
  localparam logic [10:0] EXP_S0    = 11'b0_0_00_0_1_1_0_010;
  localparam logic [10:0] EXP_S1    = 11'b1_0_01_0_1_1_0_010;
  localparam logic [10:0] EXP_S2    = 11'b0_1_01_0_1_1_0_010;
  localparam logic [10:0] EXP_S3    = 11'b1_1_10_0_1_1_0_010;
  localparam logic [10:0] EXP_DONE  = 11'b0_0_00_0_0_1_1_011;
  localparam logic [10:0] EXP_ABORT = 11'b0_0_00_0_0_1_0_100;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  mult8x8_seq_ctrl_if bus1 ();
  mult8x8_seq_ctrl_if bus2 ();

  mult8x8_seq_ctrl dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  mult8x8_seq_ctrl #(
    .DONE_CYCLES (3),
    .AUTO_CLEAR  (1'b0)
  ) dut2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus2)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Datapath model: mux4 x2, 4x4 multiplier, shifter, 16-bit accumulator.
  logic [7:0]  a_op = 8'h00;
  logic [7:0]  b_op = 8'h00;
  logic [3:0]  a_nib, b_nib;
  logic [7:0]  pp;
  logic [15:0] pp_sh;
  logic [15:0] acc;

  always_comb begin
    a_nib = bus1.sel_a ? a_op[7:4] : a_op[3:0];
    b_nib = bus1.sel_b ? b_op[7:4] : b_op[3:0];
    pp    = {4'h0, a_nib} * {4'h0, b_nib};
    case (bus1.shift_sel)
      2'd1:    pp_sh = {8'h00, pp} << 4;
      2'd2:    pp_sh = {8'h00, pp} << 8;
      default: pp_sh = {8'h00, pp};
    endcase
  end

  always @(posedge clk) begin
    if (!reset_n)          acc <= 16'h0000;
    else if (bus1.acc_clr) acc <= 16'h0000;
    else if (bus1.acc_en)  acc <= acc + pp_sh;
  end

  function automatic logic [10:0] obs1();
    return {bus1.sel_a, bus1.sel_b, bus1.shift_sel, bus1.acc_clr, bus1.acc_en,
            bus1.busy, bus1.done, bus1.state_out};
  endfunction

  function automatic logic [10:0] obs2();
    return {bus2.sel_a, bus2.sel_b, bus2.shift_sel, bus2.acc_clr, bus2.acc_en,
            bus2.busy, bus2.done, bus2.state_out};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle1(input string name);
    int k = 0;
    while (bus1.state_out !== 3'd0 && k < 20) begin
      cyc();
      k++;
    end
    n_cmp++;
    if (bus1.state_out !== 3'd0) begin
      n_err++;
      $display("FAIL %s idle1 timeout: state_out=%0d required 0", name, bus1.state_out);
    end
  endtask

  task automatic wait_idle2(input string name);
    int k = 0;
    while (bus2.state_out !== 3'd0 && k < 20) begin
      cyc();
      k++;
    end
    n_cmp++;
    if (bus2.state_out !== 3'd0) begin
      n_err++;
      $display("FAIL %s idle2 timeout: state_out=%0d required 0", name, bus2.state_out);
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    bus1.start = 1'b1;
    bus2.start = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if (obs1() !== EXP_IDLE) begin
      n_err++;
      $display("FAIL reset_dut1: got %b required %b", obs1(), EXP_IDLE);
    end
    n_cmp++;
    if (obs2() !== EXP_IDLE) begin
      n_err++;
      $display("FAIL reset_dut2: got %b required %b", obs2(), EXP_IDLE);
    end
    reset_n = 1'b1;
    cyc();
    n_cmp++;
    if (obs1() !== EXP_CLR) begin
      n_err++;
      $display("FAIL reset_release_clr: got %b required %b", obs1(), EXP_CLR);
    end
    n_cmp++;
    if (obs2() !== EXP_IDLE) begin
      n_err++;
      $display("FAIL reset_release_dut2_idle: got %b required %b", obs2(), EXP_IDLE);
    end
    bus1.start = 1'b0;
    wait_idle1("reset");
    cyc();
  endtask

  task automatic test_full_multiply(input logic [7:0] a, input logic [7:0] b,
                                    input logic [15:0] product);
    logic [10:0] e;
    a_op       = a;
    b_op       = b;
    bus1.start = 1'b1;
    cyc();
    bus1.start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      case (c)
        1:       e = EXP_CLR;
        2:       e = EXP_S0;
        3:       e = EXP_S1;
        4:       e = EXP_S2;
        5:       e = EXP_S3;
        6:       e = EXP_DONE;
        default: e = EXP_IDLE;
      endcase
      n_cmp++;
      if (obs1() !== e) begin
        n_err++;
        $display("FAIL mult_%h_%h cycle %0d: got %b required %b", a, b, c, obs1(), e);
      end
      if (c == 6) begin
        n_cmp++;
        if (acc !== product) begin
          n_err++;
          $display("FAIL mult_%h_%h acc: got %h required %h", a, b, acc, product);
        end
      end
      if (c < 7) cyc();
    end
  endtask

  task automatic test_busy_collision();
    int n_calc = 0;
    int n_done = 0;
    int n_clr  = 0;
    a_op       = 8'h12;
    b_op       = 8'h34;
    bus1.start = 1'b1;
    cyc();
    for (int c = 1; c <= 12; c++) begin
      if (bus1.acc_en)  n_calc++;
      if (bus1.done)    n_done++;
      if (bus1.acc_clr) n_clr++;
      bus1.start = (c == 1 || c == 3 || c == 6);
      if (c == 6) begin
        n_cmp++;
        if (acc !== 16'h03A8) begin
          n_err++;
          $display("FAIL collision acc: got %h required 03a8", acc);
        end
      end
      cyc();
    end
    bus1.start = 1'b0;
    n_cmp++;
    if (n_calc != 4) begin
      n_err++;
      $display("FAIL collision calc_cycles: got %0d required 4", n_calc);
    end
    n_cmp++;
    if (n_done != 1) begin
      n_err++;
      $display("FAIL collision done_cycles: got %0d required 1", n_done);
    end
    n_cmp++;
    if (n_clr != 1) begin
      n_err++;
      $display("FAIL collision clr_cycles: got %0d required 1", n_clr);
    end
    n_cmp++;
    if (obs1() !== EXP_IDLE) begin
      n_err++;
      $display("FAIL collision final: got %b required %b", obs1(), EXP_IDLE);
    end
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    int n_en   = 0;
    bus1.start = 1'b1;
    cyc();
    bus1.start = 1'b0;
    cyc();
    cyc();
    cyc();
    n_cmp++;
    if (obs1() !== EXP_S2) begin
      n_err++;
      $display("FAIL reset_mid pre: got %b required %b", obs1(), EXP_S2);
    end
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    n_cmp++;
    if (bus1.state_out !== 3'd0 || bus1.acc_en !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid after: state_out=%0d acc_en=%b required 0 0",
               bus1.state_out, bus1.acc_en);
    end
    for (int c = 0; c < 10; c++) begin
      if (bus1.done)   n_done++;
      if (bus1.acc_en) n_en++;
      cyc();
    end
    n_cmp++;
    if (n_done != 0 || n_en != 0) begin
      n_err++;
      $display("FAIL reset_mid residue: done=%0d acc_en=%0d required 0 0", n_done, n_en);
    end
  endtask

  task automatic test_param_sweep();
    logic [10:0] e;
    bus2.start = 1'b1;
    cyc();
    for (int c = 1; c <= 12; c++) begin
      case (c)
        1, 9:       e = EXP_S0;
        2, 10:      e = EXP_S1;
        3, 11:      e = EXP_S2;
        4, 12:      e = EXP_S3;
        5, 6, 7:    e = EXP_DONE;
        default:    e = EXP_IDLE;
      endcase
      n_cmp++;
      if (obs2() !== e) begin
        n_err++;
        $display("FAIL sweep cycle %0d: got %b required %b", c, obs2(), e);
      end
      cyc();
    end
    bus2.start = 1'b0;
    wait_idle2("sweep");
    cyc();
  endtask

`ifdef MULT_CTRL_ABORT_EN
  task automatic test_abort();
    int n_done = 0;
    int n_en   = 0;
    bus1.abort = 1'b1;
    cyc();
    bus1.abort = 1'b0;
    n_cmp++;
    if (obs1() !== EXP_IDLE) begin
      n_err++;
      $display("FAIL abort_in_idle: got %b required %b", obs1(), EXP_IDLE);
    end
    bus1.start = 1'b1;
    cyc();
    bus1.start = 1'b0;
    cyc();
    cyc();
    n_cmp++;
    if (obs1() !== EXP_S1) begin
      n_err++;
      $display("FAIL abort pre: got %b required %b", obs1(), EXP_S1);
    end
    bus1.abort = 1'b1;
    cyc();
    bus1.abort = 1'b0;
    n_cmp++;
    if (obs1() !== EXP_ABORT) begin
      n_err++;
      $display("FAIL abort state: got %b required %b", obs1(), EXP_ABORT);
    end
    cyc();
    n_cmp++;
    if (obs1() !== EXP_IDLE) begin
      n_err++;
      $display("FAIL abort return: got %b required %b", obs1(), EXP_IDLE);
    end
    for (int c = 0; c < 6; c++) begin
      if (bus1.done)   n_done++;
      if (bus1.acc_en) n_en++;
      cyc();
    end
    n_cmp++;
    if (n_done != 0 || n_en != 0) begin
      n_err++;
      $display("FAIL abort residue: done=%0d acc_en=%0d required 0 0", n_done, n_en);
    end
  endtask
`endif

  initial begin
    reset_n    = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
`ifdef MULT_CTRL_ABORT_EN
    bus1.abort = 1'b0;
    bus2.abort = 1'b0;
`endif
    test_reset();
    test_full_multiply(8'hFF, 8'hFF, 16'hFE01);
    test_full_multiply(8'hA7, 8'h3C, 16'h2724);
    test_busy_collision();
    test_reset_mid();
    test_param_sweep();
`ifdef MULT_CTRL_ABORT_EN
    test_abort();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
